spi_cmd_sequencer: RTL



---
 rtl/spi_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: synchronises the SPI instruction-register strobe, captures
// and decodes each new instruction, and sequences arm / trigger / readout /
// core-reset controls toward the analog front end. Status is returned as reg4.
// Optional readout watchdog: define SPI_CMD_TIMEOUT_EN to build it.
module spi_cmd_sequencer #(
  parameter int SYNC_STAGES      = 2,
  parameter int RST_PULSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic       iclk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic [7:0] trigger_channel_mask,
  input  logic [7:0] mode,
  input  logic       instr_wr,
  input  logic       ro_done,
  output logic       arm,
  output logic [7:0] trig_out,
  output logic       ro_start,
  output logic       core_rst,
  output logic [7:0] status
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_READOUT   = 2'd2,
    S_RST_PULSE = 2'd3
  } state_t;

  localparam logic [7:0] OP_START      = 8'h01;
  localparam logic [7:0] OP_STOP       = 8'h02;
  localparam logic [7:0] OP_SW_RESET   = 8'h03;
  localparam logic [7:0] OP_FORCE_TRIG = 8'h04;
  localparam logic [7:0] OP_READOUT    = 8'h05;
  localparam logic [7:0] OP_CLEAR      = 8'h06;

  localparam int             RCW      = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_PULSE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic                   sync_prev_reg;
  logic                   sync_fall;

  logic       cmd_valid_reg;
  logic [7:0] cmd_reg;
  logic [7:0] mask_reg;
  logic       rearm_reg;

  state_t         state_reg;
  state_t         state_next;
  logic [RCW-1:0] rst_cnt_reg;
  logic           arm_reg;
  logic           core_rst_reg;
  logic           ro_start_reg;
  logic [7:0]     trig_out_reg;
  logic           illegal_reg;
  logic           drop_reg;
  logic           timeout_flag;

  logic cmd_legal;
  logic cmd_accept;
  logic cmd_go;
  logic do_stop_like;
  logic do_readout;
  logic do_force;
  logic do_clear;
  logic do_swreset;
  logic wd_expire;

  // mode[7:1] carry nothing for this block; TIMEOUT_CYCLES only matters with the watchdog
  logic unused_cfg;
  assign unused_cfg = &{1'b0, mode[7:1], (TIMEOUT_CYCLES > 0)};

  assign sync_out  = sync_reg[SYNC_STAGES-1];
  assign sync_fall = sync_prev_reg & ~sync_out;

  // Shift the asynchronous latch-enable through the synchroniser chain
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], instr_wr};
      sync_prev_reg <= sync_out;
    end
  end

  // Latch closing (falling strobe) means the register contents are stable: capture them
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      cmd_valid_reg <= 1'b0;
      cmd_reg       <= '0;
      mask_reg      <= '0;
      rearm_reg     <= 1'b0;
    end else begin
      cmd_valid_reg <= sync_fall;
      if (sync_fall) begin
        cmd_reg   <= instruction;
        mask_reg  <= trigger_channel_mask;
        rearm_reg <= mode[0];
      end
    end
  end

  // Classify the captured command against the current state
  always_comb begin
    cmd_legal  = 1'b1;
    cmd_accept = 1'b0;
    case (cmd_reg)
      OP_START:      cmd_accept = (state_reg == S_IDLE) || (state_reg == S_ARMED);
      OP_STOP:       cmd_accept = (state_reg != S_RST_PULSE);
      OP_SW_RESET:   cmd_accept = 1'b1;
      OP_FORCE_TRIG: cmd_accept = (state_reg == S_ARMED);
      OP_READOUT:    cmd_accept = (state_reg == S_IDLE) || (state_reg == S_ARMED);
      OP_CLEAR:      cmd_accept = 1'b1;
      default:       cmd_legal  = 1'b0;
    endcase
  end

  assign cmd_go       = cmd_valid_reg & cmd_legal & cmd_accept;
  assign do_readout   = cmd_go && (cmd_reg == OP_READOUT);
  assign do_force     = cmd_go && (cmd_reg == OP_FORCE_TRIG);
  assign do_clear     = cmd_go && (cmd_reg == OP_CLEAR);
  assign do_swreset   = cmd_go && (cmd_reg == OP_SW_RESET);
  assign do_stop_like = do_swreset || (cmd_go && (cmd_reg == OP_STOP));

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int             TCW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] WD_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] wd_cnt_reg;
  logic           timeout_reg;

  // ro_done on the last watchdog cycle completes the readout normally
  assign wd_expire    = (state_reg == S_READOUT) && (wd_cnt_reg == WD_LAST) && !ro_done;
  assign timeout_flag = timeout_reg;

  // Watchdog counts cycles spent in READOUT and raises the sticky timeout flag
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if ((state_reg == S_READOUT) && (state_next == S_READOUT)) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end else begin
        wd_cnt_reg <= '0;
      end
      if (wd_expire && !do_stop_like) begin
        timeout_reg <= 1'b1;
      end else if (do_clear) begin
        timeout_reg <= 1'b0;
      end
    end
  end
`else
  assign wd_expire    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Next state: autonomous exits first, an accepted command overrides them
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_READOUT: begin
        if (ro_done) begin
          state_next = rearm_reg ? S_ARMED : S_IDLE;
        end else if (wd_expire) begin
          state_next = S_IDLE;
        end
      end
      S_RST_PULSE: begin
        if (rst_cnt_reg == '0) begin
          state_next = S_IDLE;
        end
      end
      default: ;
    endcase
    if (cmd_go) begin
      case (cmd_reg)
        OP_START:    state_next = S_ARMED;
        OP_STOP:     state_next = S_IDLE;
        OP_SW_RESET: state_next = S_RST_PULSE;
        OP_READOUT:  state_next = S_READOUT;
        default: ;
      endcase
    end
  end

  // State register, pulse counter, sticky flags and registered outputs
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      rst_cnt_reg  <= '0;
      arm_reg      <= 1'b0;
      core_rst_reg <= 1'b0;
      ro_start_reg <= 1'b0;
      trig_out_reg <= '0;
      illegal_reg  <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      arm_reg      <= (state_next == S_ARMED);
      core_rst_reg <= (state_next == S_RST_PULSE);
      ro_start_reg <= do_readout;
      trig_out_reg <= do_force ? mask_reg : 8'h00;
      if (do_swreset) begin
        rst_cnt_reg <= RST_LOAD;
      end else if ((state_reg == S_RST_PULSE) && (rst_cnt_reg != '0)) begin
        rst_cnt_reg <= rst_cnt_reg - 1'b1;
      end
      if (cmd_valid_reg && !cmd_legal) begin
        illegal_reg <= 1'b1;
      end else if (do_clear) begin
        illegal_reg <= 1'b0;
      end
      if (cmd_valid_reg && cmd_legal && !cmd_accept) begin
        drop_reg <= 1'b1;
      end else if (do_clear) begin
        drop_reg <= 1'b0;
      end
    end
  end

  assign arm      = arm_reg;
  assign core_rst = core_rst_reg;
  assign ro_start = ro_start_reg;
  assign trig_out = trig_out_reg;
  assign status   = {2'b00, timeout_flag, drop_reg, illegal_reg, arm_reg, state_reg};

endmodule
